// File: rtl/cpu_cu.sv
// Multi-cycle fetch/decode/execute control unit driving cpu_eu and the memory handshake.
// Optional memory wait timeout (HALT with bus_err) is enabled by defining CU_TIMEOUT_EN.
module cpu_cu #(
  parameter logic [3:0] ALU_PASS_R = 4'h0,
  parameter logic [3:0] ALU_PASS_S = 4'h1,
  parameter int         TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR_OUT,
  input  logic        C,
  input  logic        N,
  input  logic        Z,
  input  logic        mem_rdy,
  output logic [3:0]  Alu_Op,
  output logic [2:0]  W_Adr,
  output logic [2:0]  R_Adr,
  output logic [2:0]  S_Adr,
  output logic        adr_sel,
  output logic        s_sel,
  output logic        reg_w_en,
  output logic        ir_ld,
  output logic        pc_ld,
  output logic        pc_inc,
  output logic        pc_sel,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        halted,
  output logic        illegal,
  output logic        bus_err
);

  typedef enum logic [3:0] {
    S_RST      = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EX_ALU   = 4'd3,
    S_EX_LD    = 4'd4,
    S_EX_ST    = 4'd5,
    S_EX_JR    = 4'd6,
    S_EX_BR    = 4'd7,
    S_HALT     = 4'd8,
    S_HALT_ILL = 4'd9,
    S_HALT_BUS = 4'd10
  } state_t;

  localparam logic [2:0] CL_ALU  = 3'b000;
  localparam logic [2:0] CL_LD   = 3'b001;
  localparam logic [2:0] CL_ST   = 3'b010;
  localparam logic [2:0] CL_JR   = 3'b011;
  localparam logic [2:0] CL_BR   = 3'b100;
  localparam logic [2:0] CL_HALT = 3'b101;

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_flags;
  logic       w_timeout;

  // Branch condition against the stored {Cf, Nf, Zf}, never the live ALU flags.
  function automatic logic f_br_take(input logic [1:0] cond, input logic [2:0] flags);
    logic take;
    case (cond)
      2'b00:   take = 1'b1;
      2'b01:   take = flags[0];
      2'b10:   take = flags[1];
      2'b11:   take = flags[2];
      default: take = 1'b0;
    endcase
    return take;
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next;
    end
  end

  // Flag register, captured only while an ALU instruction executes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_flags <= 3'b000;
    end else if (r_state == S_EX_ALU) begin
      r_flags <= {C, N, Z};
    end else begin
      r_flags <= r_flags;
    end
  end

`ifdef CU_TIMEOUT_EN
  localparam logic [4:0] LP_WAIT_LAST = 5'(TIMEOUT - 1);

  logic [4:0] r_wait;
  logic       w_wait_st;

  assign w_wait_st = (r_state == S_FETCH) || (r_state == S_EX_LD) || (r_state == S_EX_ST);
  assign w_timeout = w_wait_st && !mem_rdy && (r_wait == LP_WAIT_LAST);

  // Memory wait counter; restarts whenever the state changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait <= 5'd0;
    end else if (w_next != r_state) begin
      r_wait <= 5'd0;
    end else if (w_wait_st && !mem_rdy) begin
      r_wait <= r_wait + 5'd1;
    end else begin
      r_wait <= r_wait;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  // Next-state and control outputs; outputs default to the IR fields with strobes low.
  always_comb begin
    w_next   = r_state;
    Alu_Op   = IR_OUT[15:12];
    W_Adr    = IR_OUT[8:6];
    R_Adr    = IR_OUT[5:3];
    S_Adr    = IR_OUT[2:0];
    adr_sel  = 1'b0;
    s_sel    = 1'b0;
    reg_w_en = 1'b0;
    ir_ld    = 1'b0;
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    pc_sel   = 1'b0;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    halted   = 1'b0;
    illegal  = 1'b0;
    bus_err  = 1'b0;
    case (r_state)
      S_RST: begin
        Alu_Op = 4'h0;
        W_Adr  = 3'b000;
        R_Adr  = 3'b000;
        S_Adr  = 3'b000;
        w_next = S_FETCH;
      end
      S_FETCH: begin
        mem_rd = 1'b1;
        if (w_timeout) begin
          w_next = S_HALT_BUS;
        end else if (mem_rdy) begin
          ir_ld  = 1'b1;
          pc_inc = 1'b1;
          w_next = S_DECODE;
        end else begin
          w_next = S_FETCH;
        end
      end
      S_DECODE: begin
        case (IR_OUT[11:9])
          CL_ALU:  w_next = S_EX_ALU;
          CL_LD:   w_next = S_EX_LD;
          CL_ST:   w_next = S_EX_ST;
          CL_JR:   w_next = S_EX_JR;
          CL_BR:   w_next = S_EX_BR;
          CL_HALT: w_next = S_HALT;
          default: w_next = S_HALT_ILL;
        endcase
      end
      S_EX_ALU: begin
        reg_w_en = 1'b1;
        w_next   = S_FETCH;
      end
      S_EX_LD: begin
        mem_rd  = 1'b1;
        adr_sel = 1'b1;
        if (w_timeout) begin
          w_next = S_HALT_BUS;
        end else if (mem_rdy) begin
          s_sel    = 1'b1;
          Alu_Op   = ALU_PASS_S;
          reg_w_en = 1'b1;
          w_next   = S_FETCH;
        end else begin
          w_next = S_EX_LD;
        end
      end
      S_EX_ST: begin
        mem_wr  = 1'b1;
        adr_sel = 1'b1;
        Alu_Op  = ALU_PASS_S;
        if (w_timeout) begin
          w_next = S_HALT_BUS;
        end else if (mem_rdy) begin
          w_next = S_FETCH;
        end else begin
          w_next = S_EX_ST;
        end
      end
      S_EX_JR: begin
        Alu_Op = ALU_PASS_R;
        pc_sel = 1'b1;
        pc_ld  = 1'b1;
        w_next = S_FETCH;
      end
      S_EX_BR: begin
        pc_ld  = f_br_take(IR_OUT[13:12], r_flags);
        w_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      S_HALT_ILL: begin
        halted  = 1'b1;
        illegal = 1'b1;
      end
      S_HALT_BUS: begin
        halted = 1'b1;
`ifdef CU_TIMEOUT_EN
        bus_err = 1'b1;
`endif
      end
      default: begin
        Alu_Op = 4'h0;
        W_Adr  = 3'b000;
        R_Adr  = 3'b000;
        S_Adr  = 3'b000;
        w_next = S_RST;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_cu.sv
// Scoreboard bench for cpu_cu: an instruction-level model expands each instruction into
// its expected per-cycle control vectors; a monitor compares them on the falling edge.
module tb_cpu_cu;

  typedef struct packed {
    logic [3:0] op;
    logic [2:0] w;
    logic [2:0] r;
    logic [2:0] s;
    logic adr_sel, s_sel, reg_w_en, ir_ld, pc_ld, pc_inc, pc_sel;
    logic mem_rd, mem_wr, halted, illegal, bus_err;
  } exp_t;

  typedef struct {
    logic        rst_n;
    logic [15:0] ir;
    logic        rdy;
    logic [2:0]  cnz;
    exp_t        exp;
  } cyc_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] IR_OUT = 16'h0000;
  logic        C = 1'b0, N = 1'b0, Z = 1'b0;
  logic        mem_rdy = 1'b0;
  logic [3:0]  Alu_Op;
  logic [2:0]  W_Adr, R_Adr, S_Adr;
  logic        adr_sel, s_sel, reg_w_en, ir_ld, pc_ld, pc_inc, pc_sel;
  logic        mem_rd, mem_wr, halted, illegal, bus_err;

  cpu_cu dut (
    .clk(clk), .reset(reset), .IR_OUT(IR_OUT), .C(C), .N(N), .Z(Z), .mem_rdy(mem_rdy),
    .Alu_Op(Alu_Op), .W_Adr(W_Adr), .R_Adr(R_Adr), .S_Adr(S_Adr),
    .adr_sel(adr_sel), .s_sel(s_sel), .reg_w_en(reg_w_en), .ir_ld(ir_ld),
    .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .halted(halted), .illegal(illegal), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  exp_t act;
  assign act = {Alu_Op, W_Adr, R_Adr, S_Adr, adr_sel, s_sel, reg_w_en, ir_ld, pc_ld,
                pc_inc, pc_sel, mem_rd, mem_wr, halted, illegal, bus_err};

  cyc_t        plan[$];
  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          mon_cyc = 0;

  // Architectural view kept by the model.
  logic [15:0] prev_ir;
  logic        m_c, m_n, m_z;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] r3();
    return 3'($urandom_range(0, 7));
  endfunction

  function automatic exp_t base(input logic [15:0] ir);
    exp_t e;
    e    = '0;
    e.op = ir[15:12];
    e.w  = ir[8:6];
    e.r  = ir[5:3];
    e.s  = ir[2:0];
    return e;
  endfunction

  function automatic logic br_taken(input logic [1:0] cond);
    case (cond)
      2'd0:    return 1'b1;
      2'd1:    return m_z;
      2'd2:    return m_n;
      default: return m_c;
    endcase
  endfunction

  task automatic add_cyc(input logic rst_n, input logic [15:0] ir, input logic rdy,
                         input logic [2:0] cnz, input exp_t e);
    cyc_t c;
    c.rst_n = rst_n;
    c.ir    = ir;
    c.rdy   = rdy;
    c.cnz   = cnz;
    c.exp   = e;
    plan.push_back(c);
  endtask

  task automatic do_reset();
    add_cyc(1'b0, 16'h0000, rb(), r3(), exp_t'(0));
    add_cyc(1'b1, 16'h0000, rb(), r3(), exp_t'(0));
    prev_ir = 16'h0000;
    {m_c, m_n, m_z} = 3'b000;
  endtask

  // Expand one instruction into cycles; abort=1 resets during the first store wait cycle.
  task automatic add_instr(input logic [15:0] ir, input int fw, input int ew,
                           input logic [2:0] alu_cnz, input bit abort);
    exp_t e;
    for (int i = 0; i < fw; i++) begin
      e = base(prev_ir); e.mem_rd = 1'b1;
      add_cyc(1'b1, prev_ir, 1'b0, r3(), e);
    end
    e = base(prev_ir); e.mem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1;
    add_cyc(1'b1, prev_ir, 1'b1, r3(), e);
    prev_ir = ir;
    add_cyc(1'b1, ir, rb(), r3(), base(ir));
    case (ir[11:9])
      3'b000: begin
        e = base(ir); e.reg_w_en = 1'b1;
        add_cyc(1'b1, ir, rb(), alu_cnz, e);
        {m_c, m_n, m_z} = alu_cnz;
      end
      3'b001: begin
        for (int i = 0; i < ew; i++) begin
          e = base(ir); e.mem_rd = 1'b1; e.adr_sel = 1'b1;
          add_cyc(1'b1, ir, 1'b0, r3(), e);
        end
        e = base(ir); e.op = 4'h1; e.mem_rd = 1'b1; e.adr_sel = 1'b1;
        e.s_sel = 1'b1; e.reg_w_en = 1'b1;
        add_cyc(1'b1, ir, 1'b1, r3(), e);
      end
      3'b010: begin
        e = base(ir); e.op = 4'h1; e.mem_wr = 1'b1; e.adr_sel = 1'b1;
        if (abort) begin
          add_cyc(1'b1, ir, 1'b0, r3(), e);
          add_cyc(1'b0, ir, 1'b0, r3(), exp_t'(0));
        end else begin
          for (int i = 0; i < ew; i++) add_cyc(1'b1, ir, 1'b0, r3(), e);
          add_cyc(1'b1, ir, 1'b1, r3(), e);
        end
      end
      3'b011: begin
        e = base(ir); e.op = 4'h0; e.pc_sel = 1'b1; e.pc_ld = 1'b1;
        add_cyc(1'b1, ir, rb(), r3(), e);
      end
      3'b100: begin
        e = base(ir); e.pc_ld = br_taken(ir[13:12]);
        add_cyc(1'b1, ir, rb(), r3(), e);
      end
      default: begin
        for (int i = 0; i < 4; i++) begin
          e = base(ir); e.halted = 1'b1; e.illegal = (ir[11:10] == 2'b11);
          add_cyc(1'b1, ir, rb(), r3(), e);
        end
      end
    endcase
  endtask

  function automatic logic [15:0] rand_ir(input logic [2:0] cls);
    logic [15:0] x;
    x = 16'($urandom);
    x[11:9] = cls;
    return x;
  endfunction

  // Monitor: compare the DUT outputs against the next scoreboard entry.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      if (act !== e) begin
        n_err = n_err + 1;
        $display("FAIL ctrl_vec cycle=%0d actual=%h expected=%h", mon_cyc, act, e);
      end
    end
    mon_cyc = mon_cyc + 1;
  end

  initial begin
    int n_ins;
    int ending;
    // Directed sequence: ALU, waited LOAD, branch taken then not taken, illegal class.
    do_reset();
    add_instr(16'h1000, 0, 0, 3'b001, 1'b0);
    add_instr(16'h024C, 0, 2, 3'b000, 1'b0);
    add_instr(16'h2001, 0, 0, 3'b001, 1'b0);
    add_instr(16'h1803, 0, 0, 3'b000, 1'b0);
    add_instr(16'h2001, 1, 0, 3'b110, 1'b0);
    add_instr(16'h1803, 0, 0, 3'b000, 1'b0);
    add_instr(16'h0C00, 0, 0, 3'b000, 1'b0);
    // Reset in the middle of a store, then refetch.
    do_reset();
    add_instr(16'h0400, 0, 0, 3'b000, 1'b0);
    add_instr(16'h0413, 1, 0, 3'b000, 1'b1);
    do_reset();
    add_instr(16'h3000, 0, 0, 3'b100, 1'b0);
    add_instr(16'h0A00, 0, 0, 3'b000, 1'b0);
`ifdef CU_TIMEOUT_EN
    begin
      exp_t e;
      do_reset();
      for (int i = 0; i < 16; i++) begin
        e = base(16'h0000); e.mem_rd = 1'b1;
        add_cyc(1'b1, 16'h0000, 1'b0, r3(), e);
      end
      for (int i = 0; i < 3; i++) begin
        e = base(16'h0000); e.halted = 1'b1; e.bus_err = 1'b1;
        add_cyc(1'b1, 16'h0000, rb(), r3(), e);
      end
    end
`endif
    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      do_reset();
      n_ins = $urandom_range(4, 14);
      for (int k = 0; k < n_ins; k++) begin
        add_instr(rand_ir(3'($urandom_range(0, 4))), $urandom_range(0, 3),
                  $urandom_range(0, 3), r3(), 1'b0);
      end
      ending = $urandom_range(0, 3);
      case (ending)
        0:       add_instr(rand_ir(3'b101), $urandom_range(0, 2), 0, r3(), 1'b0);
        1:       add_instr(rand_ir(3'($urandom_range(6, 7))), 0, 0, r3(), 1'b0);
        2:       add_instr(rand_ir(3'b010), $urandom_range(0, 2), 0, r3(), 1'b1);
        default: ;
      endcase
    end
    do_reset();

    foreach (plan[i]) begin
      @(posedge clk);
      #1;
      reset     = plan[i].rst_n;
      IR_OUT    = plan[i].ir;
      mem_rdy   = plan[i].rdy;
      {C, N, Z} = plan[i].cnz;
      sb_q.push_back(plan[i].exp);
    end
    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_err = n_err + 1;
      $display("FAIL sb_drain actual=%0d entries left expected=0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
